// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter: FSM state encoding and
// serial line levels. The PARITY state only exists when UART_TX_PARITY_EN
// is defined.
package uart_pkg;

   // Serial line levels
   localparam logic IDLE_LEVEL  = 1'b1;
   localparam logic START_LEVEL = 1'b0;
   localparam logic STOP_LEVEL  = 1'b1;

   // Transmitter FSM states; fixed encodings keep debug traces stable
   // across builds with and without parity.
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      FETCH  = 3'd1,
      START  = 3'd2,
      DATA   = 3'd3,
`ifdef UART_TX_PARITY_EN
      PARITY = 3'd4,
`endif
      STOP   = 3'd5
   } tx_state_t;

endpackage : uart_pkg

// File: rtl/uart_tx_if.sv
// Upstream FIFO read port seen by the UART transmitter.
// Handshake: the consumer (master) raises fifo_rd_en only while fifo_empty
// is low; each cycle with fifo_rd_en high pops exactly one word, and
// fifo_data carries that word in the following cycle (registered read).
interface uart_tx_if #(
   parameter int DATA_WIDTH = 8
) ();
   logic                  fifo_empty;
   logic                  fifo_rd_en;
   logic [DATA_WIDTH-1:0] fifo_data;

   // Transmitter side: pops words
   modport master (
      output fifo_rd_en,
      input  fifo_empty,
      input  fifo_data
   );

   // FIFO side: supplies words
   modport slave (
      input  fifo_rd_en,
      output fifo_empty,
      output fifo_data
   );
endinterface : uart_tx_if

// File: rtl/uart_baud_tick.sv
// Bit-period counter for the UART transmitter. Counts 0..CLKS_PER_BIT-1,
// wraps at each bit boundary and is held at 0 while clear_i is high.
// bit_end_o marks the last cycle of a bit, bit_pre_end_o the cycle before.
module uart_baud_tick #(
   parameter int unsigned CLKS_PER_BIT = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic clear_i,
   output logic bit_end_o,
   output logic bit_pre_end_o
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(CLKS_PER_BIT - 2);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   assign bit_end_o     = (cnt_q == CNT_LAST);
   assign bit_pre_end_o = (cnt_q == CNT_PRE);

   // Next count: clear, wrap at the bit boundary, otherwise increment
   always_comb begin
      cnt_d = cnt_q + CNT_W'(1);
      if (clear_i || bit_end_o) begin
         cnt_d = '0;
      end
   end

   // Counter register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule : uart_baud_tick

// File: rtl/uart_tx.sv
// UART transmitter fed from a synchronous FIFO with registered read data.
// Frame: start bit, DATA_WIDTH data bits LSB first, optional even parity
// bit (enabled by defining UART_TX_PARITY_EN), one stop bit. Each bit lasts
// CLKS_PER_BIT clocks. One pop per frame; a popped word is latched in the
// FETCH cycle, so the start bit begins two cycles after the pop.
module uart_tx
   import uart_pkg::*;
#(
   parameter int unsigned DATA_WIDTH   = 8,
   parameter int unsigned CLKS_PER_BIT = 16
) (
   input  logic       clk,
   input  logic       rst,
   uart_tx_if.master  fifo,
   output logic       tx,
   output logic       busy,
   output logic       tx_done,
   output tx_state_t  state_o
);

   localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);

   tx_state_t             state_q;
   logic [DATA_WIDTH-1:0] shift_q;
   logic [BIT_W-1:0]      bit_idx_q;
   logic                  tx_q;
   logic                  busy_q;
   logic                  done_q;
`ifdef UART_TX_PARITY_EN
   logic                  parity_q;
`endif

   logic baud_clear;
   logic bit_end;
   logic bit_pre_end;

   // Pop only from IDLE with data available, never while reset is asserted
   assign fifo.fifo_rd_en = rst && (state_q == IDLE) && !fifo.fifo_empty;

   // The bit counter sits at 0 until the start bit, so every bit-carrying
   // state is entered with a fresh count (later entries coincide with wrap).
   assign baud_clear = (state_q == IDLE) || (state_q == FETCH);

   uart_baud_tick #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_baud (
      .clk           (clk),
      .rst           (rst),
      .clear_i       (baud_clear),
      .bit_end_o     (bit_end),
      .bit_pre_end_o (bit_pre_end)
   );

   assign tx      = tx_q;
   assign busy    = busy_q;
   assign tx_done = done_q;
   assign state_o = state_q;

   // Frame sequencer with registered line, busy and done outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         shift_q   <= '0;
         bit_idx_q <= '0;
         tx_q      <= IDLE_LEVEL;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
         parity_q  <= 1'b0;
`endif
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               tx_q <= IDLE_LEVEL;
               if (fifo.fifo_rd_en) begin
                  state_q <= FETCH;
                  busy_q  <= 1'b1;
               end
            end

            // Read data is valid now, one cycle after the pop
            FETCH: begin
               shift_q   <= fifo.fifo_data;
               bit_idx_q <= '0;
`ifdef UART_TX_PARITY_EN
               parity_q  <= ^fifo.fifo_data;
`endif
               tx_q      <= START_LEVEL;
               state_q   <= START;
            end

            START: begin
               if (bit_end) begin
                  tx_q    <= shift_q[0];
                  shift_q <= shift_q >> 1;
                  state_q <= DATA;
               end
            end

            // shift_q[0] always holds the next bit to drive
            DATA: begin
               if (bit_end) begin
                  if (bit_idx_q == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
                     tx_q    <= parity_q;
                     state_q <= PARITY;
`else
                     tx_q    <= STOP_LEVEL;
                     state_q <= STOP;
`endif
                  end else begin
                     bit_idx_q <= bit_idx_q + BIT_W'(1);
                     tx_q      <= shift_q[0];
                     shift_q   <= shift_q >> 1;
                  end
               end
            end

`ifdef UART_TX_PARITY_EN
            PARITY: begin
               if (bit_end) begin
                  tx_q    <= STOP_LEVEL;
                  state_q <= STOP;
               end
            end
`endif

            // Done is raised one edge early so it lands on the last stop cycle
            STOP: begin
               if (bit_pre_end) begin
                  done_q <= 1'b1;
               end
               if (bit_end) begin
                  tx_q    <= IDLE_LEVEL;
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end
            end

            default: begin
               tx_q    <= IDLE_LEVEL;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

endmodule : uart_tx

// File: tb/tb_uart_tx.sv
// Bench for uart_tx with CLKS_PER_BIT=4, DATA_WIDTH=8. Drives a small
// registered-read FIFO model and checks line waveform, pops, busy, tx_done.
module tb_uart_tx;
   import uart_pkg::*;

   localparam int DW  = 8;
   localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
   localparam int NB = 11;
`else
   localparam int NB = 10;
`endif

   logic      clk = 1'b0;
   logic      rst = 1'b0;
   logic      tx;
   logic      busy;
   logic      tx_done;
   tx_state_t state_dbg;

   uart_tx_if #(.DATA_WIDTH(DW)) bus ();

   uart_tx #(
      .DATA_WIDTH   (DW),
      .CLKS_PER_BIT (CPB)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .fifo    (bus),
      .tx      (tx),
      .busy    (busy),
      .tx_done (tx_done),
      .state_o (state_dbg)
   );

   // Clock
   always #5 clk = ~clk;

   // FIFO model: push from the test, pop with registered read data
   logic [7:0] mem [0:15];
   int wr_ptr  = 0;
   int rd_ptr  = 0;
   int pop_cnt = 0;

   assign bus.fifo_empty = (wr_ptr == rd_ptr);

   always @(posedge clk) begin
      if (bus.fifo_rd_en) begin
         bus.fifo_data <= mem[rd_ptr % 16];
         rd_ptr        <= rd_ptr + 1;
         pop_cnt       <= pop_cnt + 1;
      end
   end

   task automatic push(input logic [7:0] d);
      mem[wr_ptr % 16] = d;
      wr_ptr = wr_ptr + 1;
   endtask

   // Continuous protocol monitor
   int rd_empty_viol = 0;
   int rd_rst_viol   = 0;
   int done_total    = 0;

   always @(negedge clk) begin
      if (bus.fifo_rd_en && bus.fifo_empty) rd_empty_viol++;
      if (!rst && bus.fifo_rd_en) rd_rst_viol++;
      if (tx_done) done_total++;
   end

   // Scoreboard counters
   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Vector table: payload, hand-computed line bits (index 0 sent first:
   // start, d0..d7, stop) and even parity of the payload.
   typedef struct {
      logic [7:0] data;
      logic [9:0] line;
      logic       par;
   } vec_t;

   vec_t vecs [6];

   function automatic logic exp_bit(input vec_t v, input int k);
`ifdef UART_TX_PARITY_EN
      if (k == 9)  return v.par;
      if (k == 10) return 1'b1;
`endif
      return v.line[k];
   endfunction

   // Waits for the pop, then checks FETCH gap, every line bit, tx_done
   // position and count, busy and the pop count for one frame. Ends at the
   // sample point of the last stop cycle.
   task automatic run_frame(input vec_t v, input int exp_wait, input string tag);
      int   waited   = 0;
      int   pops0    = pop_cnt;
      int   done_cnt = 0;
      int   done_at  = 0;
      int   busy_low = 0;
      logic got;
      logic want;
      while (!bus.fifo_rd_en && waited < 500) begin
         @(negedge clk);
         waited++;
      end
      check($sformatf("%s pop_seen", tag), bus.fifo_rd_en, 1);
      if (!bus.fifo_rd_en) return;
      if (exp_wait >= 0) check($sformatf("%s pop_wait", tag), waited, exp_wait);
      check($sformatf("%s tx_idle_gap", tag), tx, 1);
      @(negedge clk);
      check($sformatf("%s tx_fetch_gap", tag), tx, 1);
      check($sformatf("%s busy_fetch", tag), busy, 1);
      for (int k = 0; k < NB; k++) begin
         want = exp_bit(v, k);
         got  = want;
         for (int j = 0; j < CPB; j++) begin
            @(negedge clk);
            if (tx !== want && got === want) got = tx;
            if (!busy) busy_low++;
            if (tx_done) begin
               done_cnt++;
               done_at = k * CPB + j + 1;
            end
         end
         check($sformatf("%s bit%0d", tag, k), got, want);
      end
      check($sformatf("%s done_count", tag), done_cnt, 1);
      check($sformatf("%s done_cycle", tag), done_at, NB * CPB);
      check($sformatf("%s busy_low", tag), busy_low, 0);
      check($sformatf("%s pops", tag), pop_cnt, pops0 + 1);
   endtask

   // Watchdog
   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int e_tx;
      int e_busy;
      int e_rd;
      int pops0;
      int done0;
      int waited;

      vecs[0] = '{data: 8'hA5, line: 10'h34A, par: 1'b0};
      vecs[1] = '{data: 8'h07, line: 10'h20E, par: 1'b1};
      vecs[2] = '{data: 8'h03, line: 10'h206, par: 1'b0};
      vecs[3] = '{data: 8'h00, line: 10'h200, par: 1'b0};
      vecs[4] = '{data: 8'hFF, line: 10'h3FE, par: 1'b0};
      vecs[5] = '{data: 8'h55, line: 10'h2AA, par: 1'b0};

      // Reset state
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check("rst tx", tx, 1);
      check("rst busy", busy, 0);
      check("rst tx_done", tx_done, 0);
      check("rst rd_en", bus.fifo_rd_en, 0);
      check("rst state", 32'(state_dbg), 32'(IDLE));
      rst = 1'b1;

      // Idle with empty FIFO for 100 cycles
      e_tx = 0; e_busy = 0; e_rd = 0;
      repeat (100) begin
         @(negedge clk);
         if (tx !== 1'b1) e_tx++;
         if (busy !== 1'b0) e_busy++;
         if (bus.fifo_rd_en !== 1'b0) e_rd++;
      end
      check("idle tx_errs", e_tx, 0);
      check("idle busy_errs", e_busy, 0);
      check("idle rd_errs", e_rd, 0);

      // Single frames from the table
      for (int i = 0; i < 6; i++) begin
         push(vecs[i].data);
         #1;
         run_frame(vecs[i], 0, $sformatf("single%0d", i));
         @(negedge clk);
         check($sformatf("single%0d busy_after", i), busy, 0);
         check($sformatf("single%0d tx_after", i), tx, 1);
      end

      // Back-to-back: three preloaded bytes, next pop in first IDLE cycle
      pops0 = pop_cnt;
      push(vecs[3].data);
      push(vecs[4].data);
      push(vecs[5].data);
      #1;
      run_frame(vecs[3], 0, "b2b0");
      run_frame(vecs[4], 1, "b2b1");
      run_frame(vecs[5], 1, "b2b2");
      check("b2b pops", pop_cnt - pops0, 3);
      @(negedge clk);
      check("b2b busy_after", busy, 0);

      // Reset during DATA bit 3, with a second byte waiting
      pops0 = pop_cnt;
      done0 = done_total;
      push(vecs[0].data);
      push(vecs[5].data);
      #1;
      waited = 0;
      while (!bus.fifo_rd_en && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      check("abort pop_seen", bus.fifo_rd_en, 1);
      repeat (19) @(negedge clk);
      check("abort state_data", 32'(state_dbg), 32'(DATA));
      rst = 1'b0;
      #1;
      check("abort tx", tx, 1);
      check("abort busy", busy, 0);
      check("abort tx_done", tx_done, 0);
      check("abort rd_en", bus.fifo_rd_en, 0);
      check("abort state", 32'(state_dbg), 32'(IDLE));
      repeat (5) @(negedge clk);
      check("abort pops_in_reset", pop_cnt, pops0 + 1);
      check("abort no_done", done_total, done0);
      rst = 1'b1;
      #1;
      run_frame(vecs[5], 0, "after_reset");
      check("after_reset total_pops", pop_cnt, pops0 + 2);

      // Global protocol properties
      check("rd_en_while_empty", rd_empty_viol, 0);
      check("rd_en_in_reset", rd_rst_viol, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_uart_tx
